// File: rtl/alu_share_arbiter_if.sv
// Bundle of per-core request lanes, grant/completion returns and the shared ALU port.
// The master view belongs to the cores plus the ALU; the slave view belongs to the arbiter.
interface alu_share_arbiter_if #(
   parameter int WIDTH   = 12,
   parameter int N_CORES = 4
);
   logic [N_CORES-1:0]       req;
   logic [3*N_CORES-1:0]     req_op;
   logic [WIDTH*N_CORES-1:0] req_a;
   logic [WIDTH*N_CORES-1:0] req_b;
   logic [N_CORES-1:0]       gnt;
   logic [N_CORES-1:0]       done;
   logic [WIDTH-1:0]         result;
   logic                     busy;
   logic [2:0]               alu_op;
   logic [WIDTH-1:0]         alu_a;
   logic [WIDTH-1:0]         alu_b;
   logic [WIDTH-1:0]         alu_result;

   modport master (
      output req, req_op, req_a, req_b, alu_result,
      input  gnt, done, result, busy, alu_op, alu_a, alu_b
   );

   modport slave (
      input  req, req_op, req_a, req_b, alu_result,
      output gnt, done, result, busy, alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational ALU among N_CORES requesters.
// Operands are latched at grant and held until the registered result is returned.
module alu_share_arbiter #(
   parameter int WIDTH      = 12,
   parameter int N_CORES    = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus
);
   localparam int               IDX_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam logic [IDX_W:0]   NC_W     = (IDX_W+1)'(N_CORES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);
   localparam logic [2:0]       OP_MUL   = 3'd4;
   localparam logic [2:0]       OP_IDLE  = 3'd6;
   localparam logic [3:0]       MUL_LOAD = 4'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
   logic [IDX_W-1:0] owner_r, owner_s;
   logic [3:0]       cnt_r, cnt_s;
   logic [N_CORES-1:0] gnt_r, gnt_s;
   logic [N_CORES-1:0] done_r, done_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic [2:0]       alu_op_r, alu_op_s;
   logic [WIDTH-1:0] alu_a_r, alu_a_s;
   logic [WIDTH-1:0] alu_b_r, alu_b_s;
   logic             busy_r, busy_s;

   logic [2:0]       op_arr_s [N_CORES];
   logic [WIDTH-1:0] a_arr_s  [N_CORES];
   logic [WIDTH-1:0] b_arr_s  [N_CORES];
   logic [IDX_W-1:0] win_idx_s;
   logic             win_found_s;
   logic [IDX_W:0]   cand_s;
   logic             hit_s;

   for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
      assign op_arr_s[i] = bus.req_op[3*i +: 3];
      assign a_arr_s[i]  = bus.req_a[WIDTH*i +: WIDTH];
      assign b_arr_s[i]  = bus.req_b[WIDTH*i +: WIDTH];
   end

   // Round-robin search: first requesting core at or after rr_ptr, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      hit_s       = 1'b0;
      for (int off = 0; off < N_CORES; off++) begin
         cand_s      = {1'b0, rr_ptr_r} + (IDX_W+1)'(off);
         cand_s      = (cand_s >= NC_W) ? (cand_s - NC_W) : cand_s;
         hit_s       = ~win_found_s & bus.req[cand_s[IDX_W-1:0]];
         win_idx_s   = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
         win_found_s = win_found_s | hit_s;
      end
   end

   // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_s  = state_r;
      rr_ptr_s = rr_ptr_r;
      owner_s  = owner_r;
      cnt_s    = cnt_r;
      gnt_s    = gnt_r;
      done_s   = done_r;
      result_s = result_r;
      alu_op_s = alu_op_r;
      alu_a_s  = alu_a_r;
      alu_b_s  = alu_b_r;
      case (state_r)
         IDLE: begin
            done_s = '0;
            if (win_found_s) begin
               owner_s  = win_idx_s;
               alu_op_s = op_arr_s[win_idx_s];
               alu_a_s  = a_arr_s[win_idx_s];
               alu_b_s  = b_arr_s[win_idx_s];
               gnt_s    = N_CORES'(1) << win_idx_s;
               cnt_s    = (op_arr_s[win_idx_s] == OP_MUL) ? MUL_LOAD : 4'd0;
               state_s  = EXEC;
            end else begin
               alu_op_s = OP_IDLE;
               gnt_s    = '0;
            end
         end
         EXEC: begin
            if (cnt_r != 4'd0) begin
               cnt_s = cnt_r - 4'd1;
            end else begin
               result_s = bus.alu_result;
               done_s   = gnt_r;
               state_s  = RESP;
            end
         end
         RESP: begin
            gnt_s    = '0;
            done_s   = '0;
            alu_op_s = OP_IDLE;
            rr_ptr_s = (owner_r == LAST_IDX) ? '0 : (owner_r + IDX_W'(1));
            state_s  = IDLE;
         end
         default: begin
            gnt_s    = '0;
            done_s   = '0;
            alu_op_s = OP_IDLE;
            cnt_s    = 4'd0;
            state_s  = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // Register bank; asynchronous reset aborts any operation without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         rr_ptr_r <= '0;
         owner_r  <= '0;
         cnt_r    <= 4'd0;
         gnt_r    <= '0;
         done_r   <= '0;
         result_r <= '0;
         alu_op_r <= OP_IDLE;
         alu_a_r  <= '0;
         alu_b_r  <= '0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         rr_ptr_r <= rr_ptr_s;
         owner_r  <= owner_s;
         cnt_r    <= cnt_s;
         gnt_r    <= gnt_s;
         done_r   <= done_s;
         result_r <= result_s;
         alu_op_r <= alu_op_s;
         alu_a_r  <= alu_a_s;
         alu_b_r  <= alu_b_s;
         busy_r   <= busy_s;
      end
   end

   assign bus.gnt    = gnt_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.busy   = busy_r;
   assign bus.alu_op = alu_op_r;
   assign bus.alu_a  = alu_a_r;
   assign bus.alu_b  = alu_b_r;
endmodule
